clock_mode_ctrl: RTL and testbench

CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

---
 rtl/clock_ctrl_pkg.sv | 41 ++++
 rtl/clock_mode_ctrl_tick_gen.sv | 43 ++++
 rtl/clock_mode_ctrl.sv | 144 ++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings, field blanking masks and mode-sequencing helpers
// for the clock-setting controller.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10,
        MODE_SET_SEC = 2'b11
    } mode_e;

    localparam logic [5:0] MASK_NONE = 6'b000000;
    localparam logic [5:0] MASK_HR   = 6'b110000;
    localparam logic [5:0] MASK_MIN  = 6'b001100;
    localparam logic [5:0] MASK_SEC  = 6'b000011;

    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_RUN:     nxt = MODE_SET_HR;
            MODE_SET_HR:  nxt = MODE_SET_MIN;
            MODE_SET_MIN: nxt = MODE_SET_SEC;
            MODE_SET_SEC: nxt = MODE_RUN;
            default:      nxt = MODE_RUN;
        endcase
        return nxt;
    endfunction

    function automatic logic [5:0] field_mask(input mode_e cur);
        logic [5:0] m;
        case (cur)
            MODE_SET_HR:  m = MASK_HR;
            MODE_SET_MIN: m = MASK_MIN;
            MODE_SET_SEC: m = MASK_SEC;
            MODE_RUN:     m = MASK_NONE;
            default:      m = MASK_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_tick_gen.sv
// Free-running divider: counts 0..DIV-1 and flags the last count, so the
// parent sees one tick per DIV cycles. clr restarts the count from zero.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart on clear, wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded from the register only, so clr logic in the parent can depend
    // on tick without forming a combinational loop.
    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode/set controller for a digital clock: button edge detection, mode FSM,
// increment strobes, 1 Hz time base, set-mode timeout and digit blinking.
module clock_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int BLINK_HZ  = 2,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       sec_tick,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic [5:0] blink_mask
);

    localparam int            BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int            TW        = $clog2(TIMEOUT_S + 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_S - 1);

    mode_e         mode_q, mode_d;
    logic          mode_prev_q, inc_prev_q;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          sec_tick_q, sec_tick_d;
    logic          inc_hr_q, inc_hr_d;
    logic          inc_min_q, inc_min_d;
    logic          clr_sec_q, clr_sec_d;
    logic [5:0]    blink_mask_q, blink_mask_d;

    logic mode_edge_s, inc_edge_s, in_set_s, timeout_hit_s, mode_chg_s;
    logic sec_wrap_s, blink_wrap_s, sec_clr_s, blink_clr_s;

    assign mode_edge_s = mode_btn & ~mode_prev_q;
    assign inc_edge_s  = inc_btn & ~inc_prev_q;
    assign in_set_s    = (mode_q != MODE_RUN);

    // Any button edge in a SET mode restarts the idle second so the timeout
    // measures whole idle seconds; every mode change also restarts it, which
    // gives the full-second first tick on entry to RUN.
    assign sec_clr_s   = mode_chg_s | (inc_edge_s & in_set_s);
    assign blink_clr_s = mode_chg_s;

    tick_gen #(.DIV(CLK_HZ)) u_sec_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (sec_clr_s),
        .tick (sec_wrap_s)
    );

    tick_gen #(.DIV(BLINK_DIV)) u_blink_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (blink_clr_s),
        .tick (blink_wrap_s)
    );

    // Next mode: a mode edge always wins; otherwise the idle timeout forces RUN.
    always_comb begin
        timeout_hit_s = in_set_s & sec_wrap_s & ~mode_edge_s & ~inc_edge_s &
                        (to_cnt_q == TO_LAST);
        if (mode_edge_s) begin
            mode_d = next_mode(mode_q);
        end else if (timeout_hit_s) begin
            mode_d = MODE_RUN;
        end else begin
            mode_d = mode_q;
        end
        mode_chg_s = (mode_d != mode_q);
    end

    // Next values for counters, blink phase and the registered outputs.
    always_comb begin
        if ((mode_d == MODE_RUN) || mode_chg_s || inc_edge_s) begin
            to_cnt_d = '0;
        end else if (sec_wrap_s) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (mode_chg_s) begin
            blink_phase_d = 1'b0;
        end else if (blink_wrap_s) begin
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_phase_d = blink_phase_q;
        end

        sec_tick_d = sec_wrap_s & (mode_q == MODE_RUN) & (mode_d == MODE_RUN);
        inc_hr_d   = inc_edge_s & ~mode_edge_s & (mode_q == MODE_SET_HR);
        inc_min_d  = inc_edge_s & ~mode_edge_s & (mode_q == MODE_SET_MIN);
        clr_sec_d  = inc_edge_s & ~mode_edge_s & (mode_q == MODE_SET_SEC);

        if (mode_d == MODE_RUN) begin
            blink_mask_d = MASK_NONE;
        end else if (blink_phase_d) begin
            blink_mask_d = field_mask(mode_d);
        end else begin
            blink_mask_d = MASK_NONE;
        end
    end

    // State and output registers; edge registers track the buttons even in
    // reset so a button held across release is not seen as a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= MODE_RUN;
            mode_prev_q   <= mode_btn;
            inc_prev_q    <= inc_btn;
            to_cnt_q      <= '0;
            blink_phase_q <= 1'b0;
            sec_tick_q    <= 1'b0;
            inc_hr_q      <= 1'b0;
            inc_min_q     <= 1'b0;
            clr_sec_q     <= 1'b0;
            blink_mask_q  <= MASK_NONE;
        end else begin
            mode_q        <= mode_d;
            mode_prev_q   <= mode_btn;
            inc_prev_q    <= inc_btn;
            to_cnt_q      <= to_cnt_d;
            blink_phase_q <= blink_phase_d;
            sec_tick_q    <= sec_tick_d;
            inc_hr_q      <= inc_hr_d;
            inc_min_q     <= inc_min_d;
            clr_sec_q     <= clr_sec_d;
            blink_mask_q  <= blink_mask_d;
        end
    end

    assign mode       = mode_q;
    assign sec_tick   = sec_tick_q;
    assign inc_hr     = inc_hr_q;
    assign inc_min    = inc_min_q;
    assign clr_sec    = clr_sec_q;
    assign blink_mask = blink_mask_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed testbench for clock_mode_ctrl with CLK_HZ=8, BLINK_HZ=2, TIMEOUT_S=3.
module tb_clock_mode_ctrl;

    localparam int CLK_HZ    = 8;
    localparam int BLINK_HZ  = 2;
    localparam int TIMEOUT_S = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_btn;
    logic       inc_btn;
    logic       sec_tick, inc_hr, inc_min, clr_sec;
    logic [1:0] mode;
    logic [5:0] blink_mask;
    logic [11:0] obs;

    int tests_run    = 0;
    int tests_failed = 0;

    clock_mode_ctrl #(
        .CLK_HZ    (CLK_HZ),
        .BLINK_HZ  (BLINK_HZ),
        .TIMEOUT_S (TIMEOUT_S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode_btn   (mode_btn),
        .inc_btn    (inc_btn),
        .sec_tick   (sec_tick),
        .inc_hr     (inc_hr),
        .inc_min    (inc_min),
        .clr_sec    (clr_sec),
        .mode       (mode),
        .blink_mask (blink_mask)
    );

    always #5 clk = ~clk;

    // {mode, blink_mask, sec_tick, inc_hr, inc_min, clr_sec}
    assign obs = {mode, blink_mask, sec_tick, inc_hr, inc_min, clr_sec};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        rst = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0;
        repeat (3) step();
        exp = {2'b00, 6'b000000, 4'b0000};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_state: got %b expected %b", obs, exp);
        end
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            step();
            exp = {2'b00, 6'b000000, ((c % 8) == 0), 3'b000};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL idle_run c=%0d: got %b expected %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_mode_cycle();
        logic [11:0] exp;
        logic [1:0]  m;
        logic [5:0]  f;
        for (int i = 0; i < 3; i++) begin
            m = 2'(i + 1);
            f = 6'b110000 >> (2 * i);
            press_mode();
            for (int c = 0; c < 6; c++) begin
                exp = {m, (((c / 2) % 2) == 1) ? f : 6'b000000, 4'b0000};
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("FAIL mode_cycle m=%b c=%0d: got %b expected %b", m, c, obs, exp);
                end
                step();
            end
        end
        press_mode();
        for (int c = 0; c <= 8; c++) begin
            exp = {2'b00, 6'b000000, (c == 8), 3'b000};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL back_to_run c=%0d: got %b expected %b", c, obs, exp);
            end
            if (c < 8) step();
        end
    endtask

    task automatic test_simultaneous();
        press_mode();
        step();
        tests_run++;
        if (mode !== 2'b01) begin
            tests_failed++;
            $display("FAIL simul_pre_mode: got %b expected %b", mode, 2'b01);
        end
        mode_btn = 1'b1; inc_btn = 1'b1;
        step();
        mode_btn = 1'b0; inc_btn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tests_run++;
            if ({mode, inc_hr, inc_min, clr_sec} !== 5'b10000) begin
                tests_failed++;
                $display("FAIL simul c=%0d: got %b expected %b", c, {mode, inc_hr, inc_min, clr_sec}, 5'b10000);
            end
            step();
        end
    endtask

    task automatic test_inc_hold();
        logic [4:0] exp;
        tests_run++;
        if (mode !== 2'b10) begin
            tests_failed++;
            $display("FAIL inc_hold_pre_mode: got %b expected %b", mode, 2'b10);
        end
        inc_btn = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            exp = {2'b10, 1'b0, (c == 1), 1'b0};
            tests_run++;
            if ({mode, inc_hr, inc_min, clr_sec} !== exp || sec_tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL inc_hold c=%0d: got %b tick=%b expected %b tick=0", c, {mode, inc_hr, inc_min, clr_sec}, sec_tick, exp);
            end
        end
        inc_btn = 1'b0;
        step();
    endtask

    task automatic test_inc_map();
        press_mode();
        step();
        inc_btn = 1'b1; step(); inc_btn = 1'b0;
        tests_run++;
        if ({mode, inc_hr, inc_min, clr_sec} !== 5'b11001) begin
            tests_failed++;
            $display("FAIL inc_sec_pulse: got %b expected %b", {mode, inc_hr, inc_min, clr_sec}, 5'b11001);
        end
        step();
        tests_run++;
        if ({inc_hr, inc_min, clr_sec} !== 3'b000) begin
            tests_failed++;
            $display("FAIL inc_sec_after: got %b expected %b", {inc_hr, inc_min, clr_sec}, 3'b000);
        end
        press_mode();
        step();
        inc_btn = 1'b1; step(); inc_btn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tests_run++;
            if ({mode, inc_hr, inc_min, clr_sec} !== 5'b00000) begin
                tests_failed++;
                $display("FAIL inc_run c=%0d: got %b expected %b", c, {mode, inc_hr, inc_min, clr_sec}, 5'b00000);
            end
            step();
        end
        press_mode();
        step();
        inc_btn = 1'b1; step(); inc_btn = 1'b0;
        tests_run++;
        if ({mode, inc_hr, inc_min, clr_sec} !== 5'b01100) begin
            tests_failed++;
            $display("FAIL inc_hr_pulse: got %b expected %b", {mode, inc_hr, inc_min, clr_sec}, 5'b01100);
        end
        step();
        tests_run++;
        if ({inc_hr, inc_min, clr_sec} !== 3'b000) begin
            tests_failed++;
            $display("FAIL inc_hr_after: got %b expected %b", {inc_hr, inc_min, clr_sec}, 3'b000);
        end
    endtask

    task automatic test_timeout();
        logic [5:0] exp;
        press_mode();
        step();
        press_mode();
        for (int c = 1; c <= 32; c++) begin
            step();
            exp = {(c < 24) ? 2'b11 : 2'b00, (c == 32), 3'b000};
            tests_run++;
            if ({mode, sec_tick, inc_hr, inc_min, clr_sec} !== exp) begin
                tests_failed++;
                $display("FAIL timeout c=%0d: got %b expected %b", c, {mode, sec_tick, inc_hr, inc_min, clr_sec}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_set();
        logic [11:0] exp;
        press_mode();
        step();
        tests_run++;
        if (mode !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_mid_pre_mode: got %b expected %b", mode, 2'b01);
        end
        rst = 1'b1; inc_btn = 1'b1; mode_btn = 1'b1;
        step();
        exp = {2'b00, 6'b000000, 4'b0000};
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL rst_mid_state: got %b expected %b", obs, exp);
        end
        step();
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp = {2'b00, 6'b000000, (c == 8), 3'b000};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL rst_release_held c=%0d: got %b expected %b", c, obs, exp);
            end
        end
        inc_btn = 1'b0; mode_btn = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0;
        test_reset();
        test_mode_cycle();
        test_simultaneous();
        test_inc_hold();
        test_inc_map();
        test_timeout();
        test_reset_mid_set();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
